weight_loader: RTL and testbench

- Upstream fill stage for the weight BRAM banks that the weight buffer later reads for the systolic array.
- Accepts a byte stream of filter weights over a valid/ready handshake and writes each byte into one of 16 single-byte BRAM banks.
- Bank/address layout: conv1 region is banks 0-5, addresses 0-24; conv2 region is banks 0-15, addresses 25-50.
- Signals completion so the controller can start weight readout.

---
 rtl/weight_loader_if.sv | 25 ++
 rtl/weight_loader.sv | 170 +++++++++++++++++
 tb/tb_weight_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_if.sv
// Byte-stream handshake carrying filter weights into the weight loader.
// The master drives beats. The slave (weight_loader) accepts a beat when
// s_valid && s_ready.
interface weight_loader_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/weight_loader.sv
// Weight BRAM fill stage.
// Streams weight bytes into 16 single-byte banks in bank-major order.
// - conv1 region: banks 0-5, addresses 0-24.
// - conv2 region: banks 0-15, addresses 25-50.
// Each write is registered one cycle after its beat is accepted. load_done
// pulses in the same cycle as the final write. load_err flags an s_last
// that does not line up with the final beat.
module weight_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int NUM_BANK = 16,
  parameter int C1_BANKS = 6,
  parameter int C1_DEPTH = 25,
  parameter int C1_BASE  = 0,
  parameter int C2_BANKS = 16,
  parameter int C2_DEPTH = 26,
  parameter int C2_BASE  = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                nth_conv_i,
  weight_loader_if.slave      s,
  output logic [NUM_BANK-1:0] wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                busy,
  output logic                load_done,
  output logic                load_err
);

  localparam int MAX_DEPTH = (C1_DEPTH > C2_DEPTH) ? C1_DEPTH : C2_DEPTH;
  localparam int BANK_W    = $clog2(NUM_BANK);
  localparam int ENT_W     = $clog2(MAX_DEPTH);

  localparam logic [BANK_W-1:0] C1_LAST_BANK = BANK_W'(C1_BANKS - 1);
  localparam logic [BANK_W-1:0] C2_LAST_BANK = BANK_W'(C2_BANKS - 1);
  localparam logic [ENT_W-1:0]  C1_LAST_ENT  = ENT_W'(C1_DEPTH - 1);
  localparam logic [ENT_W-1:0]  C2_LAST_ENT  = ENT_W'(C2_DEPTH - 1);
  localparam logic [ADDR_W-1:0] C1_BASE_A    = ADDR_W'(C1_BASE);
  localparam logic [ADDR_W-1:0] C2_BASE_A    = ADDR_W'(C2_BASE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                conv_sel_q, conv_sel_d;
  logic [BANK_W-1:0]   bank_cnt_q, bank_cnt_d;
  logic [ENT_W-1:0]    ent_cnt_q, ent_cnt_d;
  logic                load_err_q, load_err_d;
  logic [NUM_BANK-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  // Region geometry for the load in progress.
  logic [BANK_W-1:0] last_bank;
  logic [ENT_W-1:0]  last_ent;
  logic [ADDR_W-1:0] base_addr;
  logic              beat_acc;
  logic              final_beat;

  assign last_bank  = conv_sel_q ? C2_LAST_BANK : C1_LAST_BANK;
  assign last_ent   = conv_sel_q ? C2_LAST_ENT  : C1_LAST_ENT;
  assign base_addr  = conv_sel_q ? C2_BASE_A    : C1_BASE_A;
  assign beat_acc   = (state_q == S_LOAD) && s.s_valid;
  assign final_beat = (bank_cnt_q == last_bank) && (ent_cnt_q == last_ent);

  // Status outputs depend only on the state, so they read 0 during reset.
  assign s.s_ready = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD);
  assign load_done = (state_q == S_DONE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign load_err  = load_err_q;

  // Next-state, counter and write-port logic.
  // NOTE: every _d gets a default before the case statement, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    conv_sel_d = conv_sel_q;
    bank_cnt_d = bank_cnt_q;
    ent_cnt_d  = ent_cnt_q;
    load_err_d = load_err_q;
    wr_en_d    = '0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          conv_sel_d = nth_conv_i;
          bank_cnt_d = '0;
          ent_cnt_d  = '0;
          load_err_d = 1'b0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        if (beat_acc) begin
          wr_en_d   = NUM_BANK'(1) << bank_cnt_q;
          wr_addr_d = base_addr + ADDR_W'(ent_cnt_q);
          wr_data_d = s.s_data;
          if (final_beat || s.s_last) begin
            // Either the region is full or the stream ended early.
            // A disagreement between the two is an error, but the load
            // still finishes.
            if (final_beat != s.s_last) begin
              load_err_d = 1'b1;
            end
            bank_cnt_d = '0;
            ent_cnt_d  = '0;
            state_d    = S_DONE;
          end else if (ent_cnt_q == last_ent) begin
            ent_cnt_d  = '0;
            bank_cnt_d = bank_cnt_q + BANK_W'(1);
          end else begin
            ent_cnt_d  = ent_cnt_q + ENT_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples its pre-edge _d value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, error flag and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_sel_q <= 1'b0;
      bank_cnt_q <= '0;
      ent_cnt_q  <= '0;
      load_err_q <= 1'b0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      conv_sel_q <= conv_sel_d;
      bank_cnt_q <= bank_cnt_d;
      ent_cnt_q  <= ent_cnt_d;
      load_err_q <= load_err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader.
// Drives hand-sequenced loads and checks every write against the
// bank-major address map.
module tb_weight_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        nth_conv_i;
  logic [15:0] wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int          chk_cnt;
  int          pass_cnt;
  int          wr_cnt;
  logic [15:0] en_or;

  weight_loader_if #(.DATA_W(8)) s_if ();

  weight_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .nth_conv_i (nth_conv_i),
    .s          (s_if),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock, sample just after the edge, and log any write.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_en != 16'h0) wr_cnt++;
    en_or = en_or | wr_en;
  endtask

  task automatic start(input logic conv);
    load_start = 1'b1;
    nth_conv_i = conv;
    tick();
    load_start = 1'b0;
    nth_conv_i = 1'b0;
    check("start busy", 32'(busy), 32'd1);
    check("start s_ready", 32'(s_if.s_ready), 32'd1);
    check("start load_err", 32'(load_err), 32'd0);
  endtask

  // One accepted beat k, with the write it must produce one cycle later.
  task automatic beat(input int k, input logic last, input int bank, input int addr,
                      input logic exp_done);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 8'(k % 256);
    s_if.s_last  = last;
    check($sformatf("s_ready beat%0d", k), 32'(s_if.s_ready), 32'd1);
    tick();
    check($sformatf("wr_en beat%0d", k), 32'(wr_en), 32'(16'(1) << bank));
    check($sformatf("wr_addr beat%0d", k), 32'(wr_addr), 32'(addr));
    check($sformatf("wr_data beat%0d", k), 32'(wr_data), 32'(k % 256));
    check($sformatf("load_done beat%0d", k), 32'(load_done), 32'(exp_done));
    check($sformatf("busy beat%0d", k), 32'(busy), 32'(!exp_done));
  endtask

  task automatic gap(input int k);
    s_if.s_valid = 1'b0;
    tick();
    check($sformatf("gap wr_en before beat%0d", k), 32'(wr_en), 32'd0);
    check($sformatf("gap busy before beat%0d", k), 32'(busy), 32'd1);
  endtask

  // The cycle after load_done the block is idle again.
  task automatic after_done(input string tag);
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    tick();
    check({tag, " idle load_done"}, 32'(load_done), 32'd0);
    check({tag, " idle wr_en"}, 32'(wr_en), 32'd0);
    check({tag, " idle s_ready"}, 32'(s_if.s_ready), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " s_ready"}, 32'(s_if.s_ready), 32'd0);
    check({tag, " wr_en"}, 32'(wr_en), 32'd0);
    check({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, " wr_data"}, 32'(wr_data), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " load_done"}, 32'(load_done), 32'd0);
    check({tag, " load_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    chk_cnt      = 0;
    pass_cnt     = 0;
    wr_cnt       = 0;
    en_or        = '0;
    rst_n        = 1'b0;
    load_start   = 1'b0;
    nth_conv_i   = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;

    // Reset state.
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Conv1 full load, back to back.
    wr_cnt = 0;
    en_or  = '0;
    start(1'b0);
    for (int k = 0; k < 150; k++) beat(k, k == 149, k / 25, k % 25, k == 149);
    check("c1 load_err", 32'(load_err), 32'd0);
    after_done("c1");
    check("c1 write count", 32'(wr_cnt), 32'd150);
    check("c1 banks 6-15 untouched", 32'(en_or[15:6]), 32'd0);

    // Conv2 full load with stall cycles.
    wr_cnt = 0;
    en_or  = '0;
    start(1'b1);
    for (int k = 0; k < 416; k++) begin
      if (k % 9 == 4) gap(k);
      beat(k, k == 415, k / 26, 25 + k % 26, k == 415);
    end
    check("c2 load_err", 32'(load_err), 32'd0);
    after_done("c2");
    check("c2 write count", 32'(wr_cnt), 32'd416);
    check("c2 all banks used", 32'(en_or), 32'hffff);

    // Early s_last on beat 30 of a conv1 load.
    wr_cnt = 0;
    start(1'b0);
    for (int k = 0; k < 30; k++) beat(k, k == 29, k / 25, k % 25, k == 29);
    check("early load_err", 32'(load_err), 32'd1);
    after_done("early");
    check("early write count", 32'(wr_cnt), 32'd30);
    check("early load_err sticky", 32'(load_err), 32'd1);

    // The next load_start clears load_err. This load also carries an
    // ignored mid-load conv2 start and is missing s_last on the final beat.
    wr_cnt = 0;
    start(1'b0);
    for (int k = 0; k < 150; k++) begin
      if (k == 50) begin
        load_start = 1'b1;
        nth_conv_i = 1'b1;
      end
      beat(k, 1'b0, k / 25, k % 25, k == 149);
      load_start = 1'b0;
      nth_conv_i = 1'b0;
    end
    check("nolast load_err", 32'(load_err), 32'd1);
    after_done("nolast");
    check("nolast write count", 32'(wr_cnt), 32'd150);

    // Asynchronous reset in the middle of a conv1 load.
    start(1'b0);
    for (int k = 0; k < 70; k++) beat(k, 1'b0, k / 25, k % 25, 1'b0);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 8'd70;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    s_if.s_valid = 1'b0;
    wr_cnt = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post-reset write count", 32'(wr_cnt), 32'd0);
    check("post-reset s_ready", 32'(s_if.s_ready), 32'd0);
    start(1'b0);
    for (int k = 0; k < 3; k++) beat(k, 1'b0, 0, k, 1'b0);
    s_if.s_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
